hdmi_pll_supervisor: RTL
========================

# hdmi_pll_supervisor

Sequencer and calibrator for the HDMI PLL: issues the PLL reset, waits for (synchronised) lock, sweeps the 4-bit feedback delay through all 16 settings while counting TMDS decode errors, applies the delay with the fewest errors, then supervises the running link. It sits in the 25 MHz reference-clock domain beside the PLL and gates downstream video with `video_ok`. It re-locks on lock loss and re-calibrates on excessive errors.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_reset` is held high per reset pulse (≥2).
- `LOCK_TIMEOUT`, 4096: cycles allowed from reset release to synchronised lock.
- `SETTLE_CYCLES`, 256: cycles after lock before errors are counted.
- `WINDOW_CYCLES`, 8192: error-counting window length (calibration and run).
- `ERR_THRESHOLD`, 16: run-mode errors per window that trigger re-calibration.
- `clk`  in  1  25 MHz reference clock, same as PLL reference.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL LOCK, asynchronous; double-flop synchronised internally.
- `tmds_err`  in  1  one-cycle pulse per decode error, already in `clk` domain.
- `cal_start`  in  1  one-cycle request to re-calibrate from any state except reset.
- `pll_reset`  out  1  active-high reset to the PLL.
- `pll_delay`  out  4  dynamic feedback delay to the PLL.
- `video_ok`  out  1  high only in RUN.
- `cal_busy`  out  1  high during the calibration sweep.
- `best_delay`  out  4  delay selected by the last completed sweep.
- `best_errs`  out  16  saturating error count of that delay.

## Operation
- Reset values: `pll_reset`=1, `pll_delay`=0, `video_ok`=0, `cal_busy`=1, `best_delay`=0, `best_errs`=16'hFFFF; state CAL_RST.
- States: CAL_RST → CAL_LOCK → CAL_SETTLE → CAL_MEAS → CAL_NEXT → (CAL_RST | APPLY_RST) ; APPLY_RST → APPLY_LOCK → RUN.
- CAL_RST: `pll_delay`=sweep index, `pll_reset`=1 for RESET_CYCLES, then CAL_LOCK.
- CAL_LOCK: wait for synced lock. Timeout scores this delay 16'hFFFF and goes to CAL_NEXT.
- CAL_SETTLE: SETTLE_CYCLES idle; lock loss scores 16'hFFFF → CAL_NEXT.
- CAL_MEAS: count `tmds_err` for WINDOW_CYCLES, saturating at 16'hFFFF; lock loss scores 16'hFFFF.
- CAL_NEXT: if score < `best_errs` (strict; ties keep the lower delay) update best. Index 15 → APPLY_RST, clear `cal_busy`; else index+1 → CAL_RST.
- APPLY_RST/APPLY_LOCK: reset PLL with `best_delay`. Timeout → APPLY_RST again (no retry limit).
- RUN: `video_ok`=1. Count errors per window; count ≥ ERR_THRESHOLD at window end → CAL_RST with fresh sweep. Synced lock low → APPLY_RST (no re-sweep).
- Sweep start (reset, `cal_start`, threshold) clears index to 0, `best_errs` to 16'hFFFF, sets `cal_busy`.
- `tmds_err` ignored outside CAL_MEAS and RUN. `cal_start` during reset-state CAL_RST of index 0 is a no-op.
- If all 16 delays score 16'hFFFF, `best_delay`=0 is applied.

## Timing
- `pll_delay` changes only on the cycle `pll_reset` rises; never while `pll_reset`=0.
- Lock latency: `pll_locked` rise to state advance = 3 cycles (2 sync + 1 registered).
- Lock loss to `video_ok`=0: 3 cycles; `pll_reset` asserts the same cycle.
- `tmds_err` on the last window cycle is counted in that window.
- All outputs registered; `cal_start` takes effect the next cycle, overriding any same-cycle lock or window event.
- Mid-operation `reset_n` low: all outputs to reset values immediately (asynchronous).

## Structure
- Shared package `hdmi_pkg`: state encoding enum, `DELAY_W`=4, `ERR_W`=16, `ERR_MAX`.
- One sub-module: `sync2` (two-flop synchroniser, async active-low reset to 0) for `pll_locked`.
- Single timer counter reused for reset, lock-timeout, settle and window phases; width `$clog2` of the largest parameter.

## Test plan
- Clean sweep: lock 50 cycles after each reset release, errors 5 per window except delay 4 with 0 → `best_delay`=4, `best_errs`=0, `video_ok`=1.
- Tie: delays 2 and 9 both 1 error, others 3 → `best_delay`=2.
- Timeout: no lock for delay 0..3 → those score 16'hFFFF, sweep continues to 15, `pll_reset` pulses 16 times plus one apply pulse.
- Run lock loss: drop `pll_locked` in RUN → `video_ok`=0 within 3 cycles, re-lock with unchanged `pll_delay`, no `cal_busy`.
- Threshold: 16 errors within one RUN window → `cal_busy`=1, `pll_delay`=0, new sweep; 15 errors → stays in RUN.
- Async reset mid-CAL_MEAS at delay 7 → `pll_reset`=1, `pll_delay`=0, `best_errs`=16'hFFFF immediately, sweep restarts at 0.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI PLL supervisor: widths, state encoding
// and a saturating error-count helper.
package hdmi_pkg;

  localparam int DELAY_W = 4;
  localparam int ERR_W   = 16;
  localparam int STATE_W = 3;

  localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [DELAY_W-1:0] DELAY_MAX = {DELAY_W{1'b1}};

  // Named state encoding; the localparams below alias it for legacy users.
  typedef enum logic [STATE_W-1:0] {
    CAL_RST    = 3'd0,
    CAL_LOCK   = 3'd1,
    CAL_SETTLE = 3'd2,
    CAL_MEAS   = 3'd3,
    CAL_NEXT   = 3'd4,
    APPLY_RST  = 3'd5,
    APPLY_LOCK = 3'd6,
    RUN        = 3'd7
  } state_e;

  localparam logic [STATE_W-1:0] ST_CAL_RST    = CAL_RST;
  localparam logic [STATE_W-1:0] ST_CAL_LOCK   = CAL_LOCK;
  localparam logic [STATE_W-1:0] ST_CAL_SETTLE = CAL_SETTLE;
  localparam logic [STATE_W-1:0] ST_CAL_MEAS   = CAL_MEAS;
  localparam logic [STATE_W-1:0] ST_CAL_NEXT   = CAL_NEXT;
  localparam logic [STATE_W-1:0] ST_APPLY_RST  = APPLY_RST;
  localparam logic [STATE_W-1:0] ST_APPLY_LOCK = APPLY_LOCK;
  localparam logic [STATE_W-1:0] ST_RUN        = RUN;

  // Adds one error pulse to a count, holding at ERR_MAX instead of wrapping.
  function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] cnt,
                                               input logic             inc);
    logic [ERR_W-1:0] res;
    res = cnt;
    if (inc && (cnt != ERR_MAX)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_pll_supervisor_sync2.sv
// Two-flop synchroniser used to bring the asynchronous PLL lock flag into
// the reference-clock domain. Both flops clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// HDMI PLL supervisor: resets the PLL, sweeps the 16 feedback-delay settings
// while scoring TMDS decode errors, applies the best one and then watches the
// running link, re-locking on lock loss and re-sweeping on excessive errors.
module hdmi_pll_supervisor
  import hdmi_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 8192,
  parameter int ERR_THRESHOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               tmds_err,
  input  logic               cal_start,
  output logic               pll_reset,
  output logic [DELAY_W-1:0] pll_delay,
  output logic               video_ok,
  output logic               cal_busy,
  output logic [DELAY_W-1:0] best_delay,
  output logic [ERR_W-1:0]   best_errs
);

  // One timer serves every timed phase, so it is sized for the longest one.
  localparam int MAX_AB    = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD    = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TIMER_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST  = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [ERR_W-1:0]   ERR_THR      = ERR_W'(ERR_THRESHOLD);

  logic [STATE_W-1:0] state;
  logic [TIMER_W-1:0] timer;
  logic [DELAY_W-1:0] sweep_idx;
  logic [ERR_W-1:0]   err_cnt;
  logic               lock_sync;

  logic               reset_done;
  logic               timeout_done;
  logic               settle_done;
  logic               window_done;
  logic [ERR_W-1:0]   err_next;
  logic               score_better;
  logic               sweep_last;
  logic [DELAY_W-1:0] apply_delay;
  logic               cal_start_ok;
  logic               run_trip;
  logic               sweep_go;

  sync2 u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_sync)
  );

  assign reset_done   = (timer == RESET_LAST);
  assign timeout_done = (timer == TIMEOUT_LAST);
  assign settle_done  = (timer == SETTLE_LAST);
  assign window_done  = (timer == WINDOW_LAST);

  // The error pulse arriving on the current cycle always belongs to the
  // current window, including the window's final cycle.
  assign err_next = err_add(err_cnt, tmds_err);

  // Strict comparison so that on a tie the earlier (lower) delay is kept.
  assign score_better = (err_cnt < best_errs);
  assign sweep_last   = (sweep_idx == DELAY_MAX);
  assign apply_delay  = score_better ? sweep_idx : best_delay;

  // A request while already sitting at the very start of a sweep changes
  // nothing, so it is simply ignored there.
  assign cal_start_ok = cal_start && !((state == ST_CAL_RST) && (sweep_idx == '0));

  // Too many errors in a completed run window force a fresh calibration,
  // unless the lock has just dropped, which is handled as a plain re-lock.
  assign run_trip = (state == ST_RUN) && lock_sync && window_done && (err_next >= ERR_THR);

  assign sweep_go = cal_start_ok || run_trip;

  // Main sequencer: a sweep restart overrides everything else that cycle;
  // otherwise each state advances on its lock, timeout or window event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CAL_RST;
      timer      <= '0;
      sweep_idx  <= '0;
      err_cnt    <= '0;
      pll_reset  <= 1'b1;
      pll_delay  <= '0;
      video_ok   <= 1'b0;
      cal_busy   <= 1'b1;
      best_delay <= '0;
      best_errs  <= ERR_MAX;
    end else if (sweep_go) begin
      state      <= ST_CAL_RST;
      timer      <= '0;
      sweep_idx  <= '0;
      err_cnt    <= '0;
      pll_reset  <= 1'b1;
      pll_delay  <= '0;
      video_ok   <= 1'b0;
      cal_busy   <= 1'b1;
      best_delay <= '0;
      best_errs  <= ERR_MAX;
    end else begin
      case (state)
        ST_CAL_RST: begin
          if (reset_done) begin
            pll_reset <= 1'b0;
            timer     <= '0;
            state     <= ST_CAL_LOCK;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_CAL_LOCK: begin
          if (lock_sync) begin
            timer <= '0;
            state <= ST_CAL_SETTLE;
          end else if (timeout_done) begin
            err_cnt <= ERR_MAX;
            timer   <= '0;
            state   <= ST_CAL_NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_CAL_SETTLE: begin
          if (!lock_sync) begin
            err_cnt <= ERR_MAX;
            timer   <= '0;
            state   <= ST_CAL_NEXT;
          end else if (settle_done) begin
            err_cnt <= '0;
            timer   <= '0;
            state   <= ST_CAL_MEAS;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_CAL_MEAS: begin
          if (!lock_sync) begin
            err_cnt <= ERR_MAX;
            timer   <= '0;
            state   <= ST_CAL_NEXT;
          end else if (window_done) begin
            err_cnt <= err_next;
            timer   <= '0;
            state   <= ST_CAL_NEXT;
          end else begin
            err_cnt <= err_next;
            timer   <= timer + 1'b1;
          end
        end

        ST_CAL_NEXT: begin
          if (score_better) begin
            best_errs  <= err_cnt;
            best_delay <= sweep_idx;
          end
          pll_reset <= 1'b1;
          timer     <= '0;
          if (sweep_last) begin
            cal_busy  <= 1'b0;
            pll_delay <= apply_delay;
            state     <= ST_APPLY_RST;
          end else begin
            sweep_idx <= sweep_idx + 4'd1;
            pll_delay <= sweep_idx + 4'd1;
            state     <= ST_CAL_RST;
          end
        end

        ST_APPLY_RST: begin
          if (reset_done) begin
            pll_reset <= 1'b0;
            timer     <= '0;
            state     <= ST_APPLY_LOCK;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_APPLY_LOCK: begin
          if (lock_sync) begin
            video_ok <= 1'b1;
            err_cnt  <= '0;
            timer    <= '0;
            state    <= ST_RUN;
          end else if (timeout_done) begin
            pll_reset <= 1'b1;
            timer     <= '0;
            state     <= ST_APPLY_RST;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RUN: begin
          if (!lock_sync) begin
            video_ok  <= 1'b0;
            pll_reset <= 1'b1;
            timer     <= '0;
            state     <= ST_APPLY_RST;
          end else if (window_done) begin
            err_cnt <= '0;
            timer   <= '0;
          end else begin
            err_cnt <= err_next;
            timer   <= timer + 1'b1;
          end
        end

        default: begin
          state     <= ST_CAL_RST;
          timer     <= '0;
          sweep_idx <= '0;
          pll_reset <= 1'b1;
          pll_delay <= '0;
          video_ok  <= 1'b0;
          cal_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
